// File: rtl/if_fetch.sv
// Instruction-fetch sequencer: one bus read per PC value, one-entry valid/ready slot toward ID.
// Optional counters are built when IF_FETCH_PERF_CNT_EN is defined; otherwise they read 0.
module if_fetch #(
  parameter logic [31:0] INST_NOP   = 32'h00000000,
  parameter int          PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_address,
  output logic                  pc_enable,
  input  logic                  flush,
  output logic [31:0]           ibus_address,
  output logic                  ibus_read,
  input  logic [31:0]           ibus_rddata,
  input  logic                  ibus_ready,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [31:0]           inst_pc,
  output logic                  inst_exc_adel,
  output logic [PERF_CNT_W-1:0] perf_fetch_cnt,
  output logic [PERF_CNT_W-1:0] perf_wait_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DRAIN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_req_addr;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_exc;

  logic        w_slot_free;
  logic        w_misalign;
  logic        w_issue;
  logic        w_load;
  logic [31:0] w_load_inst;
  logic [31:0] w_load_pc;
  logic        w_load_exc;

  assign w_slot_free = !r_inst_valid || inst_ready;
  assign w_misalign  = (pc_address[1:0] != 2'b00);
  assign w_issue     = (r_state == S_RUN) && w_slot_free && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req_addr <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue && !w_misalign && !ibus_ready)
        r_req_addr <= pc_address;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && !w_misalign && !ibus_ready) w_state_nxt = S_WAIT;
      S_WAIT:  begin
        if (ibus_ready)  w_state_nxt = S_RUN;
        else if (flush)  w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (ibus_ready) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A slot load and the PC advance are the same event.
  always_comb begin
    ibus_read    = 1'b0;
    ibus_address = pc_address;
    w_load       = 1'b0;
    w_load_inst  = ibus_rddata;
    w_load_pc    = pc_address;
    w_load_exc   = 1'b0;
    case (r_state)
      S_RUN: begin
        ibus_read  = w_issue && !w_misalign;
        w_load     = w_issue && (w_misalign || ibus_ready);
        w_load_exc = w_misalign;
        if (w_misalign) w_load_inst = INST_NOP;
      end
      S_WAIT: begin
        ibus_read    = 1'b1;
        ibus_address = r_req_addr;
        w_load       = ibus_ready && !flush;
        w_load_pc    = r_req_addr;
      end
      S_DRAIN: begin
        ibus_read    = 1'b1;
        ibus_address = r_req_addr;
      end
      default: ;
    endcase
  end

  assign pc_enable = w_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst_valid <= 1'b0;
      r_inst       <= 32'h0;
      r_inst_pc    <= 32'h0;
      r_inst_exc   <= 1'b0;
    end else if (flush) begin
      r_inst_valid <= 1'b0;
    end else if (w_load) begin
      r_inst_valid <= 1'b1;
      r_inst       <= w_load_inst;
      r_inst_pc    <= w_load_pc;
      r_inst_exc   <= w_load_exc;
    end else if (inst_ready) begin
      r_inst_valid <= 1'b0;
    end
  end

  assign inst_valid    = r_inst_valid;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign inst_exc_adel = r_inst_exc;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] r_fetch_cnt;
  logic [PERF_CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_load)
        r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if ((r_state == S_WAIT || r_state == S_DRAIN) && !ibus_ready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_wait_cnt  = r_wait_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed PC/bus/ID stimulus against a transaction-level fetch model.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_address;
  logic        pc_enable;
  logic        flush;
  logic [31:0] ibus_address;
  logic        ibus_read;
  logic [31:0] ibus_rddata;
  logic        ibus_ready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_exc_adel;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_wait_cnt;

  logic        ovr_en;
  logic [31:0] ovr_dat;

  int n_chk  = 0;
  int n_fail = 0;

  if_fetch #(.INST_NOP(32'h00000000), .PERF_CNT_W(32)) dut (
    .clk(clk), .rst(rst), .pc_address(pc_address), .pc_enable(pc_enable),
    .flush(flush), .ibus_address(ibus_address), .ibus_read(ibus_read),
    .ibus_rddata(ibus_rddata), .ibus_ready(ibus_ready), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_exc_adel(inst_exc_adel), .perf_fetch_cnt(perf_fetch_cnt),
    .perf_wait_cnt(perf_wait_cnt)
  );

  always #5 clk = ~clk;

  // Bus returns an address-derived word unless a test forces a specific value.
  assign ibus_rddata = ovr_en ? ovr_dat : (ibus_address ^ 32'h13579bdf);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an optional outstanding read (live or abandoned) plus the ID slot.
  logic        m_started, m_pend, m_pend_dead, m_v, m_exc;
  logic [31:0] m_pend_addr, m_inst, m_pc, m_fcnt, m_wcnt;

  function automatic void model_out(output logic rd, output logic [31:0] ad, output logic en);
    logic iss, mis;
    rd  = 1'b0;
    ad  = pc_address;
    en  = 1'b0;
    mis = (pc_address[1:0] != 2'b00);
    if (m_started && m_pend) begin
      rd = 1'b1;
      ad = m_pend_addr;
      en = ibus_ready && !m_pend_dead && !flush;
    end else if (m_started) begin
      iss = (!m_v || inst_ready) && !flush;
      rd  = iss && !mis;
      en  = iss && (mis || ibus_ready);
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    logic rd, en, mis;
    logic [31:0] ad;
    if (rst) begin
      m_started <= 1'b0; m_pend <= 1'b0; m_pend_dead <= 1'b0; m_pend_addr <= 32'h0;
      m_v <= 1'b0; m_inst <= 32'h0; m_pc <= 32'h0; m_exc <= 1'b0;
      m_fcnt <= 32'h0; m_wcnt <= 32'h0;
    end else begin
      model_out(rd, ad, en);
      mis = (pc_address[1:0] != 2'b00);
      if (flush) m_v <= 1'b0;
      else if (en) begin
        m_v    <= 1'b1;
        m_inst <= (!m_pend && mis) ? 32'h0 : ibus_rddata;
        m_pc   <= m_pend ? m_pend_addr : pc_address;
        m_exc  <= !m_pend && mis;
      end else if (inst_ready) m_v <= 1'b0;
      if (en) m_fcnt <= m_fcnt + 32'd1;
      if (m_pend && !ibus_ready) m_wcnt <= m_wcnt + 32'd1;
      if (m_pend) begin
        if (ibus_ready) m_pend <= 1'b0;
        else if (flush) m_pend_dead <= 1'b1;
      end else if (rd && !ibus_ready) begin
        m_pend <= 1'b1; m_pend_addr <= pc_address; m_pend_dead <= 1'b0;
      end
      m_started <= 1'b1;
    end
  end

  always @(negedge clk) begin
    logic rd, en;
    logic [31:0] ad;
    if (!rst) begin
      model_out(rd, ad, en);
      chk("m_ibus_read", {31'b0, ibus_read}, {31'b0, rd});
      chk("m_pc_enable", {31'b0, pc_enable}, {31'b0, en});
      if (rd) chk("m_ibus_address", ibus_address, ad);
      chk("m_inst_valid", {31'b0, inst_valid}, {31'b0, m_v});
      if (m_v) begin
        chk("m_inst", inst, m_inst);
        chk("m_inst_pc", inst_pc, m_pc);
        chk("m_inst_exc_adel", {31'b0, inst_exc_adel}, {31'b0, m_exc});
      end
`ifdef IF_FETCH_PERF_CNT_EN
      chk("m_perf_fetch", perf_fetch_cnt, m_fcnt);
      chk("m_perf_wait", perf_wait_cnt, m_wcnt);
`else
      chk("m_perf_fetch", perf_fetch_cnt, 32'h0);
      chk("m_perf_wait", perf_wait_cnt, 32'h0);
`endif
    end
  end

  // Acts as the PC register: advance by 4 on every edge where pc_enable was high.
  task automatic cyc();
    logic e;
    #1;
    e = pc_enable;
    @(posedge clk);
    #1;
    if (e) pc_address = pc_address + 32'd4;
  endtask

  initial begin
    pc_address = 32'hbfc00000; flush = 1'b0; ibus_ready = 1'b1; inst_ready = 1'b1;
    ovr_en = 1'b0; ovr_dat = 32'h0;
    #12;
    chk("rst_ibus_read", {31'b0, ibus_read}, 32'h0);
    chk("rst_pc_enable", {31'b0, pc_enable}, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_exc", {31'b0, inst_exc_adel}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("idle_ibus_read", {31'b0, ibus_read}, 32'h0);

    // Zero-wait streaming
    cyc(); #1;
    chk("first_read", {31'b0, ibus_read}, 32'h1);
    chk("first_addr", ibus_address, 32'hbfc00000);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("stream_inst_pc", inst_pc, 32'hbfc00000 + 32'(4 * i));
      chk("stream_pc_enable", {31'b0, pc_enable}, 32'h1);
    end

    // Three wait cycles at 0xbfc00010
    ibus_ready = 1'b0; ovr_en = 1'b1; ovr_dat = 32'h11223344;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("wait_read", {31'b0, ibus_read}, 32'h1);
      chk("wait_addr", ibus_address, 32'hbfc00010);
      chk("wait_pc_enable", {31'b0, pc_enable}, 32'h0);
      cyc();
    end
    ibus_ready = 1'b1;
    #1;
    chk("ready_read", {31'b0, ibus_read}, 32'h1);
    chk("ready_addr", ibus_address, 32'hbfc00010);
    chk("ready_pc_enable", {31'b0, pc_enable}, 32'h1);
    cyc();
    inst_ready = 1'b0; ovr_en = 1'b0;
    #1;
    chk("wait_inst", inst, 32'h11223344);
    chk("wait_inst_pc", inst_pc, 32'hbfc00010);

    // ID stalls with the slot full
    for (int k = 0; k < 5; k++) begin
      chk("stall_read", {31'b0, ibus_read}, 32'h0);
      chk("stall_pc_enable", {31'b0, pc_enable}, 32'h0);
      chk("stall_inst", inst, 32'h11223344);
      chk("stall_inst_pc", inst_pc, 32'hbfc00010);
      cyc(); #1;
    end
    inst_ready = 1'b1;
    #1;
    chk("resume_read", {31'b0, ibus_read}, 32'h1);
    chk("resume_addr", ibus_address, 32'hbfc00014);
    chk("resume_pc_enable", {31'b0, pc_enable}, 32'h1);
    cyc();

    // Flush during a slow read: response must be dropped
    ibus_ready = 1'b0; ovr_en = 1'b1; ovr_dat = 32'hdeadbeef;
    #1 chk("fl_issue_addr", ibus_address, 32'hbfc00018);
    cyc();
    flush = 1'b1; pc_address = 32'h80000180;
    #1 chk("fl_pc_enable", {31'b0, pc_enable}, 32'h0);
    cyc();
    flush = 1'b0;
    #1;
    chk("drain_valid", {31'b0, inst_valid}, 32'h0);
    chk("drain_read", {31'b0, ibus_read}, 32'h1);
    chk("drain_addr", ibus_address, 32'hbfc00018);
    cyc();
    ibus_ready = 1'b1;
    #1 chk("drain_ready_pc_enable", {31'b0, pc_enable}, 32'h0);
    cyc();
    ovr_en = 1'b0;
    #1;
    chk("redir_addr", ibus_address, 32'h80000180);
    chk("redir_pc_enable", {31'b0, pc_enable}, 32'h1);
    chk("redir_valid", {31'b0, inst_valid}, 32'h0);
    cyc(); #1;
    chk("redir_inst_pc", inst_pc, 32'h80000180);
    chk("redir_inst", inst, 32'h80000180 ^ 32'h13579bdf);

    // Misaligned PC
    pc_address = 32'hbfc00002;
    #1;
    chk("adel_read", {31'b0, ibus_read}, 32'h0);
    chk("adel_pc_enable", {31'b0, pc_enable}, 32'h1);
    cyc();
    pc_address = 32'hbfc00008;
    #1;
    chk("adel_valid", {31'b0, inst_valid}, 32'h1);
    chk("adel_exc", {31'b0, inst_exc_adel}, 32'h1);
    chk("adel_inst", inst, 32'h0);
    chk("adel_inst_pc", inst_pc, 32'hbfc00002);

    // Reset while a read is outstanding
    ibus_ready = 1'b0;
    cyc(); #1;
    chk("prerst_read", {31'b0, ibus_read}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("arst_read", {31'b0, ibus_read}, 32'h0);
    chk("arst_valid", {31'b0, inst_valid}, 32'h0);
    chk("arst_pc_enable", {31'b0, pc_enable}, 32'h0);
    chk("arst_fetch_cnt", perf_fetch_cnt, 32'h0);
    chk("arst_wait_cnt", perf_wait_cnt, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; pc_address = 32'h00001000; ibus_ready = 1'b1;

    // Mixed back-pressure after reset, checked by the model only
    for (int m = 0; m < 12; m++) begin
      cyc();
      inst_ready = m[0];
      ibus_ready = (m % 3) != 1;
    end
    inst_ready = 1'b1; ibus_ready = 1'b1;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
